// File: rtl/dpi_stream_sequencer_if.sv
// Byte-stream ingress bus for the DPI stream sequencer.
// The master (packet source) drives the beat and its framing flags.
// The slave (sequencer) returns in_ready. A beat transfers on any rising
// edge where in_valid and in_ready are both high.
interface dpi_stream_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic [5:0] in_sid;

  modport master (
    output in_valid,
    output in_data,
    output in_sop,
    output in_eop,
    output in_sid,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sop,
    input  in_eop,
    input  in_sid,
    output in_ready
  );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// DPI stream sequencer.
// Sequences packets from a byte stream into a bank of parallel regex
// matchers. For each packet it does the following:
//   - looks up the per-stream enable mask and the seen flag;
//   - pulses load_state so the matchers can restore their context;
//   - streams the bytes through;
//   - drains the matcher pipeline;
//   - pulses eop to commit the packet.
//
// All matcher-facing pulses (load_state, char_in, char_in_vld, eop) are
// registered one stage behind the FSM state, so they share a single
// timing reference:
//   - load_state in cycle L gives the first char_in_vld at L+3;
//   - there are exactly DRAIN_CYC idle cycles between the last
//     char_in_vld of a normally ended packet and its eop.
module dpi_stream_sequencer #(
  parameter int NUM_RE    = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dpi_stream_sequencer_if.slave s_in,
  input  logic                  cfg_we,
  input  logic [5:0]            cfg_sid,
  input  logic [NUM_RE-1:0]     cfg_mask,
  input  logic                  cfg_clr,
  output logic                  load_state,
  output logic                  new_stream_id,
  output logic [5:0]            stream_id,
  output logic [NUM_RE-1:0]     enable,
  output logic [7:0]            char_in,
  output logic                  char_in_vld,
  output logic                  eop,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count
);

  localparam int NUM_SID = 64;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP1,
    GAP2,
    STREAM,
    DRAIN,
    COMMIT
  } state_t;

  state_t              state;
  state_t              state_nx;

  logic [NUM_RE-1:0]   en_table [NUM_SID];
  logic [NUM_SID-1:0]  seen;

  // High once the sop beat that opened the current packet has been taken.
  // A later sop inside STREAM is then a framing error.
  logic                got_first;
  logic [DW-1:0]       drain_cnt;

  logic                ready;
  logic                stream_xfer;
  logic                err_inc;
  logic                start;

  assign s_in.in_ready = ready;
  assign busy          = (state != IDLE);

  // Next-state and handshake decode for the packet sequencing FSM.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    ready       = 1'b0;
    stream_xfer = 1'b0;
    err_inc     = 1'b0;
    start       = 1'b0;
    case (state)
      IDLE: begin
        if (s_in.in_valid && s_in.in_sop) begin
          // Hold the sop beat; it is consumed once the matchers are loaded.
          state_nx = LOAD;
          start    = 1'b1;
        end else begin
          // Anything else arriving outside a packet is swallowed as an error.
          ready = 1'b1;
          if (s_in.in_valid) begin
            err_inc = 1'b1;
          end
        end
      end
      LOAD: state_nx = GAP1;
      GAP1: state_nx = GAP2;
      GAP2: state_nx = STREAM;
      STREAM: begin
        if (s_in.in_valid && s_in.in_sop && got_first) begin
          // A new packet started before this one ended.
          // Close out the current packet and leave the sop beat waiting.
          err_inc  = 1'b1;
          state_nx = DRAIN;
        end else begin
          ready = 1'b1;
          if (s_in.in_valid) begin
            stream_xfer = 1'b1;
            if (s_in.in_eop) begin
              state_nx = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nx = COMMIT;
        end
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only.
  // Every flop then samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Per-stream configuration table and seen flags.
  // NOTE: this storage is reset explicitly. A packet arriving right after
  // reset must see an all-zero enable mask and a fresh seen flag, so the
  // storage is built from resettable flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen <= '0;
      for (int i = 0; i < NUM_SID; i++) begin
        en_table[i] <= '0;
      end
    end else begin
      if (cfg_we) begin
        en_table[cfg_sid] <= cfg_mask;
      end
      if (state == COMMIT) begin
        seen[stream_id] <= 1'b1;
      end
      // Placed last so that a clear hitting the sid being committed wins.
      if (cfg_clr) begin
        seen[cfg_sid] <= 1'b0;
      end
    end
  end

  // Registered matcher interface: packet context, byte pipe and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_state    <= 1'b0;
      eop           <= 1'b0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      stream_id     <= '0;
      enable        <= '0;
      new_stream_id <= 1'b0;
    end else begin
      load_state  <= (state == LOAD);
      eop         <= (state == COMMIT);
      char_in_vld <= stream_xfer;
      if (stream_xfer) begin
        char_in <= s_in.in_data;
      end
      // Context is captured once, on the way into LOAD.
      // It then stays frozen until the next packet starts. A config write
      // made after this point only affects later packets.
      if (start) begin
        stream_id     <= s_in.in_sid;
        enable        <= en_table[s_in.in_sid];
        new_stream_id <= ~seen[s_in.in_sid];
      end
    end
  end

  // Packet-phase bookkeeping: first-beat tracking and the drain timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      got_first <= 1'b0;
      drain_cnt <= DRAIN_LAST;
    end else begin
      if (state != STREAM) begin
        got_first <= 1'b0;
      end else if (stream_xfer) begin
        got_first <= 1'b1;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt - DW'(1);
      end else begin
        drain_cnt <= DRAIN_LAST;
      end
    end
  end

  // Committed-packet and protocol-error counters; both wrap at 2^16.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (state == COMMIT) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (err_inc) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Scoreboard bench for dpi_stream_sequencer.
// The stimulus tasks queue the expected matcher-side events for each
// packet: a load_state pulse, the char_in beats, and the eop. Each event
// carries its hand-computed context and cycle offsets. A monitor pops one
// entry for each event the DUT emits and compares it.
module tb_dpi_stream_sequencer;

  localparam int D = 4;

  typedef struct {
    int         kind;     // 0 load_state, 1 char_in_vld, 2 eop
    logic [7:0] data;
    logic [5:0] sid;
    logic [7:0] en;
    logic       nsid;
    logic [15:0] pkt;
    int         off;      // -1 = timing not checked
  } exp_t;

  typedef logic [7:0] byte_q_t[$];
  typedef int         int_q_t[$];

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [5:0]  cfg_sid;
  logic [7:0]  cfg_mask;
  logic        cfg_clr;
  logic        load_state;
  logic        new_stream_id;
  logic [5:0]  stream_id;
  logic [7:0]  enable;
  logic [7:0]  char_in;
  logic        char_in_vld;
  logic        eop;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  int n_pass = 0;
  int n_total = 0;
  exp_t sb[$];
  byte_q_t bq;
  int_q_t  gq;

  dpi_stream_sequencer_if bus ();

  dpi_stream_sequencer #(.NUM_RE(8), .DRAIN_CYC(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_in          (bus),
    .cfg_we        (cfg_we),
    .cfg_sid       (cfg_sid),
    .cfg_mask      (cfg_mask),
    .cfg_clr       (cfg_clr),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .enable        (enable),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input logic [5:0] sid,
                      input logic [7:0] en, input logic nsid, input logic [15:0] pkt,
                      input int off);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.sid = sid;
    e.en = en;
    e.nsid = nsid;
    e.pkt = pkt;
    e.off = off;
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until it transfers; the budget is bounded.
  task automatic drive_beat(input logic [7:0] d, input logic sop, input logic eopb,
                            input logic [5:0] sid);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_eop   = eopb;
    bus.in_sid   = sid;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("beat_accept_timeout", {31'd0, ok}, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  // Queue the expected events for one packet, then drive its beats.
  // gaps[k] is the number of idle source cycles before byte k (k > 0).
  task automatic send_pkt(input logic [5:0] sid, input byte_q_t bytes, input int_q_t gaps,
                          input logic last_eop, input logic [7:0] en, input logic nsid,
                          input logic [15:0] pkt, input int eop_off);
    int off;
    off = 3;
    push(0, 8'h00, sid, en, nsid, pkt, -1);
    for (int k = 0; k < bytes.size(); k++) begin
      if (k > 0) off = off + 1 + gaps[k];
      push(1, bytes[k], sid, en, nsid, pkt, off);
    end
    push(2, 8'h00, sid, en, nsid, pkt, eop_off);
    for (int k = 0; k < bytes.size(); k++) begin
      if (k > 0) idle_cycles(gaps[k]);
      drive_beat(bytes[k], (k == 0), last_eop && (k == bytes.size() - 1), sid);
    end
  endtask

  task automatic cfg_write(input logic [5:0] sid, input logic [7:0] mask);
    cfg_we   = 1'b1;
    cfg_sid  = sid;
    cfg_mask = mask;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_clear(input logic [5:0] sid);
    cfg_clr = 1'b1;
    cfg_sid = sid;
    @(posedge clk);
    #1;
    cfg_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {busy, 31'(sb.size())}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_state"}, load_state, 0);
    check({tag, "_char_in_vld"}, char_in_vld, 0);
    check({tag, "_eop"}, eop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stream_id"}, stream_id, 0);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_new_stream_id"}, new_stream_id, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  // Monitor: every matcher-side event must match the head of the scoreboard.
  initial begin : monitor
    int   cyc;
    int   load_cyc;
    int   char_cyc;
    int   kind;
    exp_t e;
    cyc = 0;
    load_cyc = 0;
    char_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (load_state === 1'b1 || char_in_vld === 1'b1 || eop === 1'b1) begin
        kind = (load_state === 1'b1) ? 0 : (char_in_vld === 1'b1) ? 1 : 2;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got event kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
          e = sb.pop_front();
          check("sb_kind", kind, e.kind);
          check("sb_stream_id", stream_id, e.sid);
          check("sb_enable", enable, e.en);
          check("sb_new_stream_id", new_stream_id, e.nsid);
          if (kind == 0) begin
            load_cyc = cyc;
          end else if (kind == 1) begin
            check("sb_char_in", char_in, e.data);
            if (e.off >= 0) check("sb_char_offset", cyc - load_cyc, e.off);
            char_cyc = cyc;
          end else begin
            check("sb_pkt_count", pkt_count, e.pkt);
            if (e.off >= 0) check("sb_eop_offset", cyc - char_cyc, e.off);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_sid   = '0;
    cfg_we   = 1'b0;
    cfg_sid  = '0;
    cfg_mask = '0;
    cfg_clr  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(1);

    // Basic 3-byte packet on a freshly configured sid.
    cfg_write(6'd5, 8'h03);
    bq = {8'h41, 8'h42, 8'h43};
    gq = {0, 0, 0};
    send_pkt(6'd5, bq, gq, 1'b1, 8'h03, 1'b1, 16'd1, D + 1);
    check("busy_in_drain", busy, 1);
    wait_idle("idle_p1");
    check("pkt_count_p1", pkt_count, 16'd1);

    // Same sid again is no longer new; after a clear it is new again.
    bq = {8'h51, 8'h52, 8'h53};
    send_pkt(6'd5, bq, gq, 1'b1, 8'h03, 1'b0, 16'd2, D + 1);
    wait_idle("idle_p2");
    cfg_clear(6'd5);
    bq = {8'h61, 8'h62, 8'h63};
    send_pkt(6'd5, bq, gq, 1'b1, 8'h03, 1'b1, 16'd3, D + 1);
    wait_idle("idle_p3");

    // Single-byte packet, sop and eop on one beat, unconfigured sid.
    bq = {8'h5A};
    gq = {0};
    send_pkt(6'd9, bq, gq, 1'b1, 8'h00, 1'b1, 16'd4, D + 1);
    wait_idle("idle_single");

    // Stray non-sop beat in IDLE is dropped and counted.
    drive_beat(8'hEE, 1'b0, 1'b0, 6'd3);
    check("err_after_stray", err_count, 16'd1);
    check("busy_after_stray", busy, 0);
    idle_cycles(3);
    check("pkt_after_stray", pkt_count, 16'd4);

    // sop mid-packet: old packet committed, error counted, new one follows.
    cfg_write(6'd7, 8'hA5);
    bq = {8'h10, 8'h11};
    gq = {0, 0};
    send_pkt(6'd7, bq, gq, 1'b0, 8'hA5, 1'b1, 16'd5, -1);
    bq = {8'h20, 8'h21};
    send_pkt(6'd7, bq, gq, 1'b1, 8'hA5, 1'b0, 16'd6, D + 1);
    wait_idle("idle_abort");
    check("err_after_abort", err_count, 16'd2);

    // Source gaps inside a packet, with a config write landing mid-packet.
    bq = {8'h01, 8'h02, 8'h03, 8'h04};
    gq = {0, 2, 0, 3};
    fork
      send_pkt(6'd5, bq, gq, 1'b1, 8'h03, 1'b0, 16'd7, D + 1);
      begin
        repeat (8) @(posedge clk);
        #1;
        cfg_write(6'd5, 8'hFF);
      end
    join
    wait_idle("idle_gaps");
    bq = {8'h77};
    gq = {0};
    send_pkt(6'd5, bq, gq, 1'b1, 8'hFF, 1'b0, 16'd8, D + 1);
    wait_idle("idle_newcfg");
    check("pkt_count_8", pkt_count, 16'd8);

    // Reset while streaming: outputs clear at once, no eop, no seen set.
    cfg_write(6'd12, 8'h0F);
    push(0, 8'h00, 6'd12, 8'h0F, 1'b1, 16'd8, -1);
    push(1, 8'h30, 6'd12, 8'h0F, 1'b1, 16'd8, 3);
    drive_beat(8'h30, 1'b1, 1'b0, 6'd12);
    check("busy_in_stream", busy, 1);
    rst_n = 1'b0;
    idle_cycles(1);
    check_all_zero("midrst");
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(D + 6);
    check("sb_empty_after_reset", sb.size(), 0);
    bq = {8'h44};
    send_pkt(6'd12, bq, gq, 1'b1, 8'h00, 1'b1, 16'd1, D + 1);
    wait_idle("idle_post_reset");
    check("err_post_reset", err_count, 16'd0);

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
